// File: rtl/gmux_pkg.sv
// Shared types and constants for the global clock mux switch controller.
package gmux_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitOff,
        StWaitOn,
        StVlpOff,
        StVlpOn,
        StVlpExit
    } gmux_sw_state_t;

    localparam int unsigned Q_TL = 0;
    localparam int unsigned Q_TR = 1;
    localparam int unsigned Q_BL = 2;
    localparam int unsigned Q_BR = 3;

endpackage

// File: rtl/gmux_settle_cnt.sv
// Loadable settle down-counter with zero flag; stops at zero, never wraps.
module gmux_settle_cnt #(
    parameter int unsigned SETTLE = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic zero_o
);

    localparam int unsigned CntW = $clog2(SETTLE + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CntW'(SETTLE - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gmux_switch_ctrl.sv
// Sequences GMUX select changes (gate-off, switch, gate-on) and VLP entry/exit
// for all clock quadrants, from the always-on housekeeping clock.
module gmux_switch_ctrl
    import gmux_pkg::*;
#(
    parameter int unsigned NSRC   = 4,
    parameter int unsigned NQUAD  = 4,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned SEL_W  = $clog2(NSRC)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    input  logic [SEL_W-1:0] req_sel_i,
    input  logic [NQUAD-1:0] req_qen_i,
    output logic             req_ready_o,
    input  logic             vlp_req_i,
    output logic [SEL_W-1:0] sel_o,
    output logic [NQUAD-1:0] qen_o,
    output logic [NQUAD-1:0] vlp_o,
    output logic             done_o,
    output logic             err_o,
    output logic             busy_o
);

    gmux_sw_state_t   state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] lsel_q, lsel_d;
    logic [NQUAD-1:0] qen_q, qen_d;
    logic [NQUAD-1:0] lqen_q, lqen_d;
    logic [NQUAD-1:0] save_qen_q, save_qen_d;
    logic [NQUAD-1:0] vlp_q, vlp_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             cnt_load;
    logic             cnt_zero;

    gmux_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (cnt_load),
        .zero_o (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        lsel_d     = lsel_q;
        qen_d      = qen_q;
        lqen_d     = lqen_q;
        save_qen_d = save_qen_q;
        vlp_d      = vlp_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cnt_load   = 1'b0;

        case (state_q)
            StIdle: begin
                // VLP entry takes priority; READY is already low in that case.
                if (vlp_req_i) begin
                    save_qen_d = qen_q;
                    qen_d      = '0;
                    cnt_load   = 1'b1;
                    state_d    = StVlpOff;
                end else if (req_valid_i) begin
                    if (32'(req_sel_i) >= NSRC) begin
                        err_d = 1'b1;
                    end else if (req_sel_i == sel_q) begin
                        qen_d  = req_qen_i;
                        done_d = 1'b1;
                    end else begin
                        lsel_d   = req_sel_i;
                        lqen_d   = req_qen_i;
                        qen_d    = '0;
                        cnt_load = 1'b1;
                        state_d  = StWaitOff;
                    end
                end
            end
            StWaitOff: begin
                if (cnt_zero) begin
                    sel_d    = lsel_q;
                    cnt_load = 1'b1;
                    state_d  = StWaitOn;
                end
            end
            StWaitOn: begin
                if (cnt_zero) begin
                    qen_d   = lqen_q;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StVlpOff: begin
                if (cnt_zero) begin
                    vlp_d   = '1;
                    state_d = StVlpOn;
                end
            end
            StVlpOn: begin
                if (!vlp_req_i) begin
                    vlp_d    = '0;
                    cnt_load = 1'b1;
                    state_d  = StVlpExit;
                end
            end
            StVlpExit: begin
                if (cnt_zero) begin
                    qen_d   = save_qen_q;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            lsel_q     <= '0;
            qen_q      <= '0;
            lqen_q     <= '0;
            save_qen_q <= '0;
            vlp_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            lsel_q     <= lsel_d;
            qen_q      <= qen_d;
            lqen_q     <= lqen_d;
            save_qen_q <= save_qen_d;
            vlp_q      <= vlp_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign req_ready_o = (state_q == StIdle) && !vlp_req_i;
    assign busy_o      = (state_q != StIdle);
    assign sel_o       = sel_q;
    assign qen_o       = qen_q;
    assign vlp_o       = vlp_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
